uart_tx_drain: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_drain.sv | 104 ++++++++++
 tb/tb_uart_tx_drain.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// ==== uart_tx_pkg : shared state encoding and frame-length helper for uart_tx_drain  |  rev 1.0 ====
`default_nettype none

package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DEFAULT_FRAME_BITS = 10;

  // Serial bits in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_width, input int parity_en, input int stop_bits);
    return 1 + data_width + parity_en + stop_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_drain.sv
// ==== uart_tx_drain : pops bytes from a FWFT FIFO and serialises them as UART frames  |  rev 1.0 ====
`default_nettype none

module uart_tx_drain
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t             state;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_bit;
  logic                  bit_end;
  logic                  last_stop;
  logic                  pop;

  assign bit_end   = (div_cnt == DIV_LAST);
  assign last_stop = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
  // Gating with reset keeps the strobe low while the block is being reset.
  assign pop       = reset & enable & ~fifo_empty & ((state == IDLE) | last_stop);
  assign fifo_rd   = pop;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_reg[0];
        PARITY:  tx <= parity_bit;
        default: tx <= 1'b1;
      endcase

      if (pop) begin
        shift_reg  <= fifo_r_data;
        parity_bit <= ^fifo_r_data;
        state      <= START;
        div_cnt    <= '0;
        bit_idx    <= '0;
        stop_idx   <= 1'b0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          div_cnt <= '0;
          case (state)
            START: state <= DATA;
            DATA: begin
              shift_reg <= shift_reg >> 1;
              if (bit_idx == BIT_LAST) begin
                bit_idx <= '0;
                state   <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
            PARITY: state <= STOP;
            STOP: begin
              if (stop_idx == STOP_LAST) begin
                stop_idx <= 1'b0;
                state    <= IDLE;
              end else begin
                stop_idx <= stop_idx + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
// ==== tb_uart_tx_drain : directed bench with FIFO model, UART receiver and byte scoreboard  |  rev 1.0 ====
`default_nettype none

module tb_uart_tx_drain;
  import uart_tx_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT fed by a small FIFO model.
  logic       enable_a = 1'b1;
  logic       fifo_empty_a, fifo_rd_a, tx_a, busy_a;
  logic [7:0] fifo_r_data_a;
  logic [7:0] mem [0:15];
  int         wp = 0;
  int         rp = 0;

  assign fifo_empty_a  = (wp == rp);
  assign fifo_r_data_a = mem[rp[3:0]];

  // Parity + two-stop-bit DUT driven directly.
  logic       enable_p = 1'b1;
  logic       fifo_empty_p = 1'b1;
  logic [7:0] fifo_r_data_p = 8'h07;
  logic       fifo_rd_p, tx_p, busy_p;

  uart_tx_drain dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .fifo_empty(fifo_empty_a),
    .fifo_r_data(fifo_r_data_a), .fifo_rd(fifo_rd_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_EN(1)) dut_p (
    .clk(clk), .reset(reset), .enable(enable_p), .fifo_empty(fifo_empty_p),
    .fifo_r_data(fifo_r_data_p), .fifo_rd(fifo_rd_p), .tx(tx_p), .busy(busy_p)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pop_cnt_a = 0;
  int         pop_cnt_p = 0;
  int         pop_cyc [$];
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_a === 1'b1) begin
      chk("rd_a_legal", {fifo_empty_a, reset}, 2'b01);
      rp        <= rp + 1;
      pop_cnt_a <= pop_cnt_a + 1;
      pop_cyc.push_back(cyc);
    end
    if (fifo_rd_p === 1'b1) begin
      chk("rd_p_legal", {fifo_empty_p, reset}, 2'b01);
      pop_cnt_p <= pop_cnt_p + 1;
    end
  end

  // Receiver for dut_a: samples mid-bit and checks each byte against the scoreboard.
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = '0;
  logic [7:0] exp_b;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx_a === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt = rx_cnt + 1;
      if (rx_cnt == CPB / 2) begin
        chk("rx_start", tx_a, 1'b0);
      end else if (rx_cnt == CPB / 2 + CPB * 9) begin
        chk("rx_stop", tx_a, 1'b1);
        chk("rx_sb_nonempty", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          chk("rx_byte", rx_byte, exp_b);
        end
        rx_active = 1'b0;
      end else if (rx_cnt > CPB / 2 && (rx_cnt - CPB / 2) % CPB == 0) begin
        rx_byte[(rx_cnt - CPB / 2) / CPB - 1] = tx_a;
      end
    end
  end

  function automatic logic [255:0] frame_wave(input logic [7:0] d, input int par, input int stops, input int n);
    logic [255:0] w;
    logic [15:0]  seq;
    int           nb;
    int           pos;
    w      = '0;
    seq    = '0;
    seq[0] = 1'b0;
    for (int k = 0; k < 8; k++) seq[1+k] = d[k];
    nb = 9;
    if (par != 0) begin
      seq[nb] = ^d;
      nb      = nb + 1;
    end
    for (int s = 0; s < stops; s++) begin
      seq[nb] = 1'b1;
      nb      = nb + 1;
    end
    w[0] = 1'b1;
    pos  = 1;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CPB; c++) begin
        w[pos] = seq[b];
        pos    = pos + 1;
      end
    end
    for (int i = pos; i < n; i++) w[i] = 1'b1;
    return w;
  endfunction

  function automatic logic [255:0] busy_wave(input int len);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < len; i++) w[i] = 1'b1;
    return w;
  endfunction

  task automatic push_a(input logic [7:0] b);
    mem[wp[3:0]] = b;
    wp = wp + 1;
    exp_q.push_back(b);
  endtask

  task automatic wait_pop(input bit sel, input int budget, input string tag);
    #1;
    for (int k = 0; k < budget; k++) begin
      if ((sel ? fifo_rd_p : fifo_rd_a) === 1'b1) break;
      @(negedge clk);
      #1;
    end
    chk(tag, sel ? fifo_rd_p : fifo_rd_a, 1'b1);
  endtask

  task automatic capture(input bit sel, input int n, output logic [255:0] tw, output logic [255:0] bw);
    tw = '0;
    bw = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel && i == 0) fifo_empty_p = 1'b1;
      tw[i] = sel ? tx_p : tx_a;
      bw[i] = sel ? busy_p : busy_a;
    end
  endtask

  logic [255:0] tw, bw;
  int           base;

  initial begin
    // Reset held for three cycles with data waiting.
    push_a(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", tx_a, 1'b1);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_rd", fifo_rd_a, 1'b0);
    end
    reset = 1'b1;
    wait_pop(1'b0, 2, "rst_release_pop");

    // Single byte 0xA5, exact line waveform and busy window.
    capture(1'b0, 162, tw, bw);
    chk("a5_wave", tw, frame_wave(8'hA5, 0, 1, 162));
    chk("a5_busy", bw, busy_wave(CPB * frame_bits(8, 0, 1)));
    chk("a5_pops", pop_cnt_a, 1);

    // Two bytes from one 16-bit word, back to back.
    pop_cyc.delete();
    push_a(8'h17);
    push_a(8'h19);
    repeat (2 * CPB * DEFAULT_FRAME_BITS + 10) @(negedge clk);
    chk("b2b_npops", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) chk("b2b_period", pop_cyc[1] - pop_cyc[0], CPB * DEFAULT_FRAME_BITS);
    chk("b2b_idle", {tx_a, busy_a}, 2'b10);

    // Enable dropped during data bit 3 of the first frame.
    base = pop_cnt_a;
    push_a(8'h5A);
    push_a(8'hC3);
    wait_pop(1'b0, 4, "en_pop1");
    repeat (71) @(negedge clk);
    enable_a = 1'b0;
    repeat (95) @(negedge clk);
    chk("en_idle", {tx_a, busy_a}, 2'b10);
    chk("en_no_pop", pop_cnt_a, base + 1);
    repeat (10) @(negedge clk);
    chk("en_still_no_pop", pop_cnt_a, base + 1);
    enable_a = 1'b1;
    #1;
    chk("en_resume_rd", fifo_rd_a, 1'b1);
    @(negedge clk);
    chk("en_gap_cycle", {tx_a, busy_a}, 2'b11);
    @(negedge clk);
    chk("en_start_bit", tx_a, 1'b0);
    repeat (170) @(negedge clk);
    chk("en_pops", pop_cnt_a, base + 2);

    // Reset pulse during data bit 4 of 0x3C drops that byte.
    base = pop_cnt_a;
    push_a(8'h3C);
    push_a(8'h81);
    wait_pop(1'b0, 4, "rst_mid_pop");
    repeat (89) @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_front());
    #1;
    chk("rst_mid_rd", fifo_rd_a, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_mid_line", {tx_a, busy_a}, 2'b10);
    chk("rst_mid_pops", pop_cnt_a, base + 1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_next_rd", fifo_rd_a, 1'b1);
    repeat (175) @(negedge clk);
    chk("rst_mid_total_pops", pop_cnt_a, base + 2);

    // Even parity with two stop bits on 0x07.
    fifo_empty_p = 1'b0;
    wait_pop(1'b1, 3, "par_pop");
    capture(1'b1, 194, tw, bw);
    chk("par_wave", tw, frame_wave(8'h07, 1, 2, 194));
    chk("par_busy", bw, busy_wave(CPB * frame_bits(8, 1, 2)));
    chk("par_pops", pop_cnt_p, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
